bfloat_to_int: RTL and testbench

Sequential bfloat16-to-signed-integer converter for the MAC output path. It takes a bfloat16 result from the add/sub/MAC datapath and returns a saturated, round-to-nearest-even signed integer. Alignment uses a one-bit-per-cycle shifter, so latency depends on the operand exponent. It uses valid/ready handshakes on both sides.

---
 rtl/bfloat_to_int_if.sv | 29 ++
 rtl/bfloat_to_int.sv | 155 +++++++++++++++
 tb/tb_bfloat_to_int.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bfloat_to_int_if.sv
// rtl/bfloat_to_int_if.sv - operand/result handshake bundle for bfloat_to_int
// Purpose: groups the operand-side and result-side valid/ready signals.
// Signals:
//   in_valid/in_ready/in_data   - bfloat16 operand {sign, exp[7:0], mant[6:0]}
//   out_valid/out_ready         - result handshake, result held until accepted
//   out_data                    - OUT_W-bit two's-complement result
//   out_flags                   - {nan, sat, inexact}
// Modports: slave = converter side, master = producer/consumer side.
interface bfloat_to_int_if #(
   parameter int OUT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [2:0]       out_flags;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_flags
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_flags
   );
endinterface

// File: rtl/bfloat_to_int.sv
// rtl/bfloat_to_int.sv - sequential bfloat16 to saturated signed integer converter
// Purpose: converts a bfloat16 operand to an OUT_W-bit two's-complement integer
//   with round-to-nearest-even and saturation. Alignment shifts one bit per
//   cycle, so latency depends on the operand exponent.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset
//   io    - bfloat_to_int_if.slave: operand handshake (in_valid/in_ready/in_data)
//           and result handshake (out_valid/out_ready/out_data/out_flags)
module bfloat_to_int #(
   parameter int OUT_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   bfloat_to_int_if.slave io
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int MW = OUT_W + 1;
   // Exponent code where E = OUT_W-1: first magnitude that no longer fits
   localparam logic [7:0] EXP_SAT = 8'(126 + OUT_W);
   // Exponent code where E = 7: the 8-bit significand is already integer-aligned
   localparam logic [7:0] EXP_ALN = 8'd134;
   // Exponent codes below this mean E < -1, i.e. magnitude below one half
   localparam logic [7:0] EXP_HALF = 8'd126;
   localparam logic [MW-1:0]    LIM_POS = MW'((1 << (OUT_W - 1)) - 1);
   localparam logic [MW-1:0]    LIM_NEG = MW'(1 << (OUT_W - 1));
   localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   logic [1:0]       r_state;
   logic             r_live;
   logic             r_sign;
   logic             r_left;
   logic             r_guard;
   logic             r_sticky;
   logic [MW-1:0]    r_mag;
   logic [7:0]       r_cnt;
   logic [OUT_W-1:0] r_out_data;
   logic [2:0]       r_out_flags;

   logic             w_sign;
   logic [7:0]       w_exp;
   logic [6:0]       w_mant;
   logic             w_in_ready;
   logic [7:0]       w_cnt;
   logic [MW-1:0]    w_mag_rnd;
   logic [MW-1:0]    w_limit;
   logic             w_inexact;

   assign w_sign = io.in_data[15];
   assign w_exp  = io.in_data[14:7];
   assign w_mant = io.in_data[6:0];

   // r_live keeps in_ready low during reset and for the release edge itself
   assign w_in_ready = (r_state == IDLE) && r_live;

   // Shift distance |E-7| taken straight from the biased exponent
   assign w_cnt = (w_exp < EXP_ALN) ? (EXP_ALN - w_exp) : (w_exp - EXP_ALN);

   // Round to nearest, ties to even on the aligned lsb
   assign w_mag_rnd = r_mag + MW'(r_guard & (r_sticky | r_mag[0]));
   assign w_limit   = r_sign ? LIM_NEG : LIM_POS;
   assign w_inexact = r_guard | r_sticky;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_live      <= 1'b0;
         r_sign      <= 1'b0;
         r_left      <= 1'b0;
         r_guard     <= 1'b0;
         r_sticky    <= 1'b0;
         r_mag       <= '0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_flags <= 3'b000;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            IDLE: begin
               if (io.in_valid && w_in_ready) begin
                  r_sign   <= w_sign;
                  r_mag    <= {{(MW-8){1'b0}}, 1'b1, w_mant};
                  r_guard  <= 1'b0;
                  r_sticky <= 1'b0;
                  r_cnt    <= w_cnt;
                  r_left   <= (w_exp > EXP_ALN);
                  r_state  <= DONE;
                  if (w_exp == 8'd0) begin
                     r_out_data  <= '0;
                     r_out_flags <= 3'b000;
                  end else if (w_exp == 8'hFF && w_mant != 7'd0) begin
                     r_out_data  <= '0;
                     r_out_flags <= 3'b100;
                  end else if (w_exp >= EXP_SAT) begin
                     // -2^(OUT_W-1) itself is representable exactly
                     if (w_sign && w_exp == EXP_SAT && w_mant == 7'd0) begin
                        r_out_data  <= SAT_NEG;
                        r_out_flags <= 3'b000;
                     end else begin
                        r_out_data  <= w_sign ? SAT_NEG : SAT_POS;
                        r_out_flags <= 3'b010;
                     end
                  end else if (w_exp < EXP_HALF) begin
                     r_out_data  <= '0;
                     r_out_flags <= 3'b001;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               // n==0 spends one cycle here without shifting
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
                  if (r_left) begin
                     r_mag <= {r_mag[MW-2:0], 1'b0};
                  end else begin
                     r_mag    <= {1'b0, r_mag[MW-1:1]};
                     r_guard  <= r_mag[0];
                     r_sticky <= r_sticky | r_guard;
                  end
               end
               if (r_cnt <= 8'd1) begin
                  r_state <= ROUND;
               end
            end
            ROUND: begin
               if (w_mag_rnd > w_limit) begin
                  r_out_data  <= r_sign ? SAT_NEG : SAT_POS;
                  r_out_flags <= {1'b0, 1'b1, w_inexact};
               end else begin
                  r_out_data  <= r_sign ? -w_mag_rnd[OUT_W-1:0] : w_mag_rnd[OUT_W-1:0];
                  r_out_flags <= {1'b0, 1'b0, w_inexact};
               end
               r_state <= DONE;
            end
            default: begin
               if (io.out_ready) begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign io.in_ready  = w_in_ready;
   assign io.out_valid = (r_state == DONE);
   assign io.out_data  = r_out_data;
   assign io.out_flags = r_out_flags;
endmodule

// File: tb/tb_bfloat_to_int.sv
// tb/tb_bfloat_to_int.sv - self-checking bench for bfloat_to_int
module tb_bfloat_to_int;
   localparam int OW = 16;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   bfloat_to_int_if #(.OUT_W(OW)) io ();

   bfloat_to_int #(.OUT_W(OW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: value = (128+mant) * 2^(E-7), rounded half-to-even by integer division
   task automatic ref_model(input logic [15:0] op, output logic [15:0] d,
                            output logic [2:0] f, output int lat);
      bit     s;
      int     e, m, ee, n, sh;
      longint sig, q, rem, half, mag, v, maxp, maxn;
      bit     inex;
      logic [63:0] vb;
      s    = op[15];
      e    = int'(op[14:7]);
      m    = int'(op[6:0]);
      ee   = e - 127;
      maxp = (64'sd1 <<< (OW - 1)) - 1;
      maxn = 64'sd1 <<< (OW - 1);
      lat  = 1;
      inex = 1'b0;
      f    = 3'b000;
      v    = 0;
      if (e == 0) begin
         v = 0; f = 3'b000;
      end else if (e == 255 && m != 0) begin
         v = 0; f = 3'b100;
      end else if (e == 255 || ee >= OW - 1) begin
         if (s && ee == OW - 1 && m == 0) begin
            v = -maxn; f = 3'b000;
         end else begin
            v = s ? -maxn : maxp; f = 3'b010;
         end
      end else if (ee < -1) begin
         v = 0; f = 3'b001;
      end else begin
         sig = 128 + m;
         n   = (ee >= 7) ? ee - 7 : 7 - ee;
         lat = ((n < 1) ? 1 : n) + 2;
         if (ee >= 7) begin
            mag = sig * (64'sd1 <<< (ee - 7));
         end else begin
            sh   = 7 - ee;
            q    = sig / (64'sd1 <<< sh);
            rem  = sig % (64'sd1 <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            inex = (rem != 0);
            mag  = q;
         end
         if (mag > (s ? maxn : maxp)) begin
            v = s ? -maxn : maxp; f = {2'b01, inex};
         end else begin
            v = s ? -mag : mag; f = {2'b00, inex};
         end
      end
      vb = v;
      d  = vb[15:0];
   endtask

   task automatic run_op(input logic [15:0] op, input int hold, input logic [15:0] exp_d,
                         input logic [2:0] exp_f, input int exp_lat, input string tag);
      int w;
      int lat;
      w = 0;
      while (!io.in_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      chk({tag, "_in_ready_wait"}, io.in_ready, 1);
      io.in_valid = 1'b1;
      io.in_data  = op;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      io.in_data  = 16'($urandom);
      lat = 1;
      while (!io.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, "_out_valid"}, io.out_valid, 1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_data"}, io.out_data, exp_d);
      chk({tag, "_flags"}, io.out_flags, exp_f);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_data"}, io.out_data, exp_d);
         chk({tag, "_hold_in_ready"}, io.in_ready, 0);
      end
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, io.in_ready, 1);
      chk({tag, "_out_valid_after"}, io.out_valid, 0);
   endtask

   typedef struct {
      logic [15:0] op;
      logic [15:0] d;
      logic [2:0]  f;
   } vec_t;

   vec_t dir_tab[11] = '{
      '{16'hC0A0, 16'hFFFB, 3'b000},
      '{16'h3FC0, 16'h0002, 3'b001},
      '{16'h4020, 16'h0002, 3'b001},
      '{16'h3F00, 16'h0000, 3'b001},
      '{16'h46FF, 16'h7F80, 3'b000},
      '{16'h4700, 16'h7FFF, 3'b010},
      '{16'hC700, 16'h8000, 3'b000},
      '{16'hFF80, 16'h8000, 3'b010},
      '{16'h7FC0, 16'h0000, 3'b100},
      '{16'h0045, 16'h0000, 3'b000},
      '{16'h3E00, 16'h0000, 3'b001}
   };

   initial begin
      logic [15:0] md;
      logic [2:0]  mf;
      int          ml;
      logic [15:0] op;
      int          hold;

      n_cmp        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      io.in_valid  = 1'b1;
      io.in_data   = 16'h4040;
      io.out_ready = 1'b0;

      // Reset with an operand offered: must not be taken
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", io.out_valid, 0);
      chk("rst_out_data", io.out_data, 0);
      chk("rst_out_flags", io.out_flags, 0);
      chk("rst_in_ready", io.in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      chk("rel_in_ready", io.in_ready, 1);
      chk("rel_out_valid", io.out_valid, 0);
      @(posedge clk); #1;
      chk("rel_no_accept", io.out_valid, 0);

      // Directed values; latency from the reference model
      foreach (dir_tab[i]) begin
         ref_model(dir_tab[i].op, md, mf, ml);
         run_op(dir_tab[i].op, 0, dir_tab[i].d, dir_tab[i].f, ml, $sformatf("dir%0d", i));
      end

      // Backpressure on 10.0 for 20 cycles, then an immediate follow-on operand
      ref_model(16'h4120, md, mf, ml);
      run_op(16'h4120, 20, 16'h000A, 3'b000, ml, "bp");
      ref_model(16'h4040, md, mf, ml);
      run_op(16'h4040, 0, 16'h0003, 3'b000, ml, "bp_next");

      // Reset in the middle of SHIFT on 0.5
      io.in_valid = 1'b1;
      io.in_data  = 16'h3F00;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_out_valid", io.out_valid, 0);
      chk("midrst_out_data", io.out_data, 0);
      chk("midrst_out_flags", io.out_flags, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready", io.in_ready, 1);
      chk("midrst_no_result", io.out_valid, 0);
      ref_model(16'h4040, md, mf, ml);
      run_op(16'h4040, 0, 16'h0003, 3'b000, ml, "midrst_next");

      // Randomised operands, biased toward the normal conversion range
      for (int k = 0; k < 200; k++) begin
         op = 16'($urandom);
         if ($urandom_range(0, 2) != 0) op[14:7] = 8'($urandom_range(120, 146));
         hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
         ref_model(op, md, mf, ml);
         run_op(op, hold, md, mf, ml, $sformatf("rnd_%04h", op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
